alu_decoder: RTL and testbench

- Second-level decoder of the single-cycle RISC-V control unit.
- Maps the main decoder's ALUOp, plus instruction fields funct3, funct7 and op, to a 3-bit ALUControl code for the ALU.
- Primary output is purely combinational, so the single-cycle datapath sees it in the same cycle.
- A registered shadow copy and an illegal-encoding monitor support pipelined reuse and debug.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_decode_comb.sv | 48 ++++
 rtl/alu_decoder.sv | 66 ++++++
 tb/tb_alu_decoder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the RISC-V ALU decoder: ALUControl codes,
// ALUOp classes from the main decoder, and the funct3 values it decodes.
package alu_pkg;

    // ALUControl operation codes seen by the ALU
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    // ALUOp classes produced by the main decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    // funct3 field values (instruction bits [14:12])
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

endpackage

// File: rtl/alu_decode_comb.sv
// Pure combinational ALU decode: ALUOp/funct3/funct7[5]/op[5] -> ALUControl
// plus an illegal-encoding flag. Build option ALU_DECODER_EXT_OPS_EN adds
// xor, sll and srl/sra decoding for R/I-type instructions.
module alu_decode_comb
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       op_5,
    output logic [2:0] alu_control,
    output logic       illegal
);

    // Decode the operation; every path defaults to add with no illegal flag
    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type sub sets both bits; addi with imm[10]=1 stays add
                    F3_ADD:  alu_control = (op_5 && funct7_5) ? ALU_SUB : ALU_ADD;
                    F3_SLT:  alu_control = ALU_SLT;
                    F3_OR:   alu_control = ALU_OR;
                    F3_AND:  alu_control = ALU_AND;
`ifdef ALU_DECODER_EXT_OPS_EN
                    F3_XOR:  alu_control = ALU_XOR;
                    F3_SLL:  alu_control = ALU_SLL;
                    // Shift direction only; arithmetic vs logical is resolved in the ALU
                    F3_SR:   alu_control = ALU_SRL;
`endif
                    default: begin
                        alu_control = ALU_ADD;
                        illegal     = 1'b1;
                    end
                endcase
            end
            default: begin
                alu_control = ALU_ADD;
                illegal     = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_decoder.sv
// Second-level ALU decoder of the single-cycle RISC-V control unit.
// Combinational ALUControl/illegal outputs, a registered shadow copy and a
// saturating illegal-encoding counter. Build option ALU_DECODER_EXT_OPS_EN
// enables the xor/sll/srl decodes inside alu_decode_comb.
module alu_decoder
    import alu_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           ALUOp,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic [6:0]           op,
    output logic [2:0]           ALUControl,
    output logic [2:0]           ALUControl_q,
    output logic                 illegal,
    output logic                 illegal_q,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic [2:0]           alu_control_d;
    logic                 illegal_d;
    logic [ERR_CNT_W-1:0] err_cnt_d;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic                 unused_bits;

    // Only funct7[5] and op[5] carry meaning for the ALU decode
    assign unused_bits = ^{funct7[6], funct7[4:0], op[6], op[4:0]};

    alu_decode_comb u_decode (
        .alu_op      (ALUOp),
        .funct3      (funct3),
        .funct7_5    (funct7[5]),
        .op_5        (op[5]),
        .alu_control (ALUControl),
        .illegal     (illegal)
    );

    // Next-state: shadow copy of the decode and a counter that sticks at all-ones
    always_comb begin
        alu_control_d = ALUControl;
        illegal_d     = illegal;
        err_cnt_d     = err_cnt_q;
        if (illegal && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // Registered outputs, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALUControl_q <= ALU_ADD;
            illegal_q    <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            ALUControl_q <= alu_control_d;
            illegal_q    <= illegal_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_alu_decoder.sv
// Self-checking bench for alu_decoder: directed cases, reset behaviour,
// counter saturation (narrow counter) and randomized decode.
module tb_alu_decoder;

    localparam int CW = 2;
    localparam int CNT_MAX = (1 << CW) - 1;
`ifdef ALU_DECODER_EXT_OPS_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [1:0]    ALUOp;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic [6:0]    op;
    logic [2:0]    ALUControl;
    logic [2:0]    ALUControl_q;
    logic          illegal;
    logic          illegal_q;
    logic [CW-1:0] err_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference state for the registered outputs
    logic [2:0] exp_ctrl_q;
    logic       exp_ill_q;
    int         exp_cnt;

    // funct3 lookup for ALUOp=10: operation code, always-legal set, extended set
    logic [2:0] tab_code [8] = '{3'b000, 3'b110, 3'b101, 3'b000,
                                 3'b100, 3'b111, 3'b011, 3'b010};
    bit         tab_base [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bit         tab_ext  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    alu_decoder #(.ERR_CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ALUOp        (ALUOp),
        .funct3       (funct3),
        .funct7       (funct7),
        .op           (op),
        .ALUControl   (ALUControl),
        .ALUControl_q (ALUControl_q),
        .illegal      (illegal),
        .illegal_q    (illegal_q),
        .err_cnt      (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Returns {illegal, ALUControl} from the decode rules
    function automatic logic [3:0] ref_decode(input logic [1:0] a, input logic [2:0] f3,
                                              input logic [6:0] f7, input logic [6:0] o);
        logic [2:0] code;
        bit         legal;
        if (a == 2'd0) return {1'b0, 3'd0};
        if (a == 2'd1) return {1'b0, 3'd1};
        if (a == 2'd3) return {1'b1, 3'd0};
        if (f3 == 3'd0) return {1'b0, 2'b00, (o[5] & f7[5])};
        legal = tab_base[f3] || (EXT && tab_ext[f3]);
        code  = legal ? tab_code[f3] : 3'd0;
        return {~legal, code};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one set of inputs at a negedge, check the decode, then the registers after the edge
    task automatic apply(input string tag, input logic [1:0] a, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [6:0] o);
        logic [3:0] r;
        ALUOp  = a;
        funct3 = f3;
        funct7 = f7;
        op     = o;
        #1;
        r = ref_decode(a, f3, f7, o);
        chk({tag, "_ctrl"}, {5'd0, ALUControl}, {5'd0, r[2:0]});
        chk({tag, "_ill"}, {7'd0, illegal}, {7'd0, r[3]});
        @(posedge clk);
        exp_ctrl_q = r[2:0];
        exp_ill_q  = r[3];
        if (r[3] && exp_cnt < CNT_MAX) exp_cnt++;
        #1;
        chk({tag, "_ctrl_q"}, {5'd0, ALUControl_q}, {5'd0, exp_ctrl_q});
        chk({tag, "_ill_q"}, {7'd0, illegal_q}, {7'd0, exp_ill_q});
        chk({tag, "_cnt"}, 8'(err_cnt), 8'(exp_cnt));
        @(negedge clk);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ctrl_q"}, {5'd0, ALUControl_q}, 8'd0);
        chk({tag, "_ill_q"}, {7'd0, illegal_q}, 8'd0);
        chk({tag, "_cnt"}, 8'(err_cnt), 8'd0);
    endtask

    initial begin
        rst_n  = 1'b1;
        ALUOp  = 2'b00;
        funct3 = 3'b000;
        funct7 = 7'b0;
        op     = 7'b0;
        exp_ctrl_q = 3'd0;
        exp_ill_q  = 1'b0;
        exp_cnt    = 0;

        // Reset asserted between edges
        #2 rst_n = 1'b0;
        #1;
        chk_reset_state("por");
        chk("por_comb_ctrl", {5'd0, ALUControl}, 8'd0);
        @(negedge clk);
        chk_reset_state("por_hold");
        rst_n = 1'b1;

        // Fixed classes
        apply("add_class", 2'b00, 3'b000, 7'b0000000, 7'b0000000);
        apply("sub_class", 2'b01, 3'b000, 7'b0000000, 7'b0000000);
        apply("add_class_x", 2'b00, 3'b111, 7'b0100000, 7'b0110011);
        apply("sub_class_x", 2'b01, 3'b010, 7'b0100000, 7'b0110011);

        // funct3=000 add/sub selection
        apply("rtype_sub", 2'b10, 3'b000, 7'b0100000, 7'b0110011);
        apply("itype_add", 2'b10, 3'b000, 7'b0000000, 7'b0010011);
        apply("op0_f1", 2'b10, 3'b000, 7'b0100000, 7'b0010011);
        apply("op1_f0", 2'b10, 3'b000, 7'b0000000, 7'b0110011);

        // slt/or/and
        apply("slt", 2'b10, 3'b010, 7'b0000000, 7'b0110011);
        apply("or", 2'b10, 3'b110, 7'b0000000, 7'b0110011);
        apply("and", 2'b10, 3'b111, 7'b0000000, 7'b0110011);

        // funct3=100 twice: illegal without the extension, counts per clock
        apply("xor_a", 2'b10, 3'b100, 7'b0000000, 7'b0110011);
        apply("xor_b", 2'b10, 3'b100, 7'b0000000, 7'b0110011);
        apply("sll", 2'b10, 3'b001, 7'b0000000, 7'b0110011);
        apply("sra", 2'b10, 3'b101, 7'b0100000, 7'b0110011);
        apply("f3_011", 2'b10, 3'b011, 7'b0000000, 7'b0110011);

        // Put something nonzero in the registers, then reset between edges
        apply("pre_rst", 2'b11, 3'b000, 7'b0, 7'b0);
        apply("pre_rst2", 2'b10, 3'b010, 7'b0, 7'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_state("mid_rst");
        chk("mid_rst_comb", {5'd0, ALUControl}, 8'b101);
        exp_ctrl_q = 3'd0;
        exp_ill_q  = 1'b0;
        exp_cnt    = 0;
        @(negedge clk);
        chk_reset_state("mid_rst_hold");
        rst_n = 1'b1;
        apply("post_rst_or", 2'b10, 3'b110, 7'b0, 7'b0);
        apply("post_rst_sub", 2'b01, 3'b000, 7'b0, 7'b0);

        // Saturation of the narrow counter
        for (int i = 0; i < 6; i++) begin
            apply($sformatf("sat%0d", i), 2'b11, 3'($urandom_range(0, 7)), 7'($urandom), 7'($urandom));
        end
        chk("sat_final", 8'(err_cnt), 8'(CNT_MAX));
        apply("sat_legal_hold", 2'b00, 3'b000, 7'b0, 7'b0);

        // Randomized decode with occasional reset pulses
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                chk_reset_state($sformatf("rnd_rst%0d", i));
                exp_ctrl_q = 3'd0;
                exp_ill_q  = 1'b0;
                exp_cnt    = 0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            apply($sformatf("rnd%0d", i), 2'($urandom), 3'($urandom), 7'($urandom), 7'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
